// File: rtl/p4_router_queue_dequeue_ctrl.sv
// Dequeue initiator for the queue state store. Picks an eligible queue round-robin,
// consumes its head pointer over AXI4-Lite, then emits the word address and an occupancy debit.
module p4_router_queue_dequeue_ctrl #(
  parameter int NUM_PAGES               = 16,
  parameter int WORDS_PER_PAGE          = 64,
  parameter int BYTES_PER_WORD          = 16,
  parameter int NUM_EGR_PORTS           = 2,
  parameter int NUM_QUEUES_PER_EGR_PORT = 4,
  parameter int NUM_QUEUES              = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
  parameter int MAX_BURST_WORDS         = 4,
  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int HW = (WORDS_PER_PAGE > 1) ? $clog2(WORDS_PER_PAGE) : 1,
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int RW = HW + PW,
  localparam int AW = (NUM_PAGES * WORDS_PER_PAGE > 1) ? $clog2(NUM_PAGES * WORDS_PER_PAGE) : 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [NUM_QUEUES-1:0]    queue_empty,
  input  logic [NUM_EGR_PORTS-1:0] egress_ready,
  output logic                     queue_head_pointer_a4l_awvalid,
  output logic [QW-1:0]            queue_head_pointer_a4l_awaddr,
  output logic                     queue_head_pointer_a4l_wvalid,
  output logic [RW-1:0]            queue_head_pointer_a4l_wdata,
  output logic                     queue_head_pointer_a4l_bready,
  output logic                     queue_head_pointer_a4l_arvalid,
  output logic [QW-1:0]            queue_head_pointer_a4l_araddr,
  input  logic                     queue_head_pointer_a4l_arready,
  input  logic                     queue_head_pointer_a4l_rvalid,
  input  logic [RW-1:0]            queue_head_pointer_a4l_rdata,
  output logic                     queue_head_pointer_a4l_rready,
  output logic                     word_rd_addr_axis_tvalid,
  input  logic                     word_rd_addr_axis_tready,
  output logic [AW-1:0]            word_rd_addr_axis_tdata,
  output logic [QW-1:0]            word_rd_addr_axis_tuser,
  output logic                     word_rd_addr_axis_tlast,
  output logic                     dequeue_queue_occupancy_axis_tvalid,
  output logic [31:0]              dequeue_queue_occupancy_axis_tdata,
  output logic [QW-1:0]            dequeue_queue_occupancy_axis_tuser,
  output logic                     dequeue_queue_occupancy_axis_tlast,
  output logic [31:0]              dequeue_word_count,
  output logic [2:0]               dbg_state_o
);

  localparam int BW = $clog2(MAX_BURST_WORDS + 1);

  // Handshakes: a transfer happens on the cycle where valid and ready are both high;
  // once valid is raised, it and its payload stay put until that cycle.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARB = 3'd1, S_AR = 3'd2, S_RD = 3'd3, S_ISSUE = 3'd4, S_SETTLE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   rr_q, rr_d;
  logic [QW-1:0]   q_q, q_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            wtvalid_q, wtvalid_d;
  logic [AW-1:0]   wtdata_q, wtdata_d;
  logic [QW-1:0]   wtuser_q, wtuser_d;
  logic [31:0]     occ_tdata_q, occ_tdata_d;
  logic [QW-1:0]   occ_tuser_q, occ_tuser_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [NUM_QUEUES-1:0] elig;
  logic                  any_elig;
  logic [QW-1:0]         grant;
  logic                  ar_hs, r_hs, word_hs;
  logic [HW-1:0]         rd_head;
  logic [PW-1:0]         rd_page;
  logic [AW-1:0]         rd_addr;

  assign ar_hs   = arvalid_q && queue_head_pointer_a4l_arready;
  assign r_hs    = rready_q && queue_head_pointer_a4l_rvalid;
  assign word_hs = wtvalid_q && word_rd_addr_axis_tready;

  assign rd_head = queue_head_pointer_a4l_rdata[RW-1 -: HW];
  assign rd_page = queue_head_pointer_a4l_rdata[PW-1:0];
  assign rd_addr = AW'(rd_page) * AW'(WORDS_PER_PAGE) + AW'(rd_head);

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      elig[q] = !queue_empty[q] && egress_ready[q / NUM_QUEUES_PER_EGR_PORT];
    end
  end

  // First eligible queue at or after rr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    any_elig = 1'b0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      idx = (int'(rr_q) + i) % NUM_QUEUES;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        grant    = QW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      q_q         <= '0;
      burst_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      wtvalid_q   <= 1'b0;
      wtdata_q    <= '0;
      wtuser_q    <= '0;
      occ_tdata_q <= '0;
      occ_tuser_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      q_q         <= q_d;
      burst_q     <= burst_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      wtvalid_q   <= wtvalid_d;
      wtdata_q    <= wtdata_d;
      wtuser_q    <= wtuser_d;
      occ_tdata_q <= occ_tdata_d;
      occ_tuser_q <= occ_tuser_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    q_d     = q_q;
    burst_d = burst_q;
    unique case (state_q)
      S_IDLE:   if (enable && any_elig) state_d = S_ARB;
      S_ARB: begin
        if (any_elig) begin
          q_d     = grant;
          burst_d = '0;
          rr_d    = (grant == QW'(NUM_QUEUES - 1)) ? '0 : grant + QW'(1);
          state_d = S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR:     if (ar_hs) state_d = S_RD;
      S_RD:     if (r_hs) state_d = S_ISSUE;
      S_ISSUE: begin
        if (word_hs) begin
          burst_d = burst_q + BW'(1);
          state_d = S_SETTLE;
        end
      end
      // queue_empty now reflects the debit of the word just issued
      S_SETTLE: begin
        if (enable && (burst_q < BW'(MAX_BURST_WORDS)) && elig[q_q]) state_d = S_AR;
        else if (enable && any_elig)                                 state_d = S_ARB;
        else                                                         state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so every strobe is a flop output.
  always_comb begin
    arvalid_d   = (state_d == S_AR);
    rready_d    = (state_d == S_RD);
    wtvalid_d   = (state_d == S_ISSUE);
    wtdata_d    = wtdata_q;
    wtuser_d    = wtuser_q;
    occ_tdata_d = occ_tdata_q;
    occ_tuser_d = occ_tuser_q;
    cnt_d       = cnt_q;
    if (state_q == S_RD && r_hs) begin
      wtdata_d    = rd_addr;
      wtuser_d    = q_q;
      occ_tdata_d = 32'(BYTES_PER_WORD);
      occ_tuser_d = q_q;
    end
    if (word_hs) cnt_d = cnt_q + 32'd1;
  end

  assign queue_head_pointer_a4l_awvalid = 1'b0;
  assign queue_head_pointer_a4l_awaddr  = '0;
  assign queue_head_pointer_a4l_wvalid  = 1'b0;
  assign queue_head_pointer_a4l_wdata   = '0;
  assign queue_head_pointer_a4l_bready  = 1'b1;
  assign queue_head_pointer_a4l_arvalid = arvalid_q;
  assign queue_head_pointer_a4l_araddr  = q_q;
  assign queue_head_pointer_a4l_rready  = rready_q;

  assign word_rd_addr_axis_tvalid = wtvalid_q;
  assign word_rd_addr_axis_tdata  = wtdata_q;
  assign word_rd_addr_axis_tuser  = wtuser_q;
  assign word_rd_addr_axis_tlast  = 1'b0;

  // The debit must land on the exact cycle the word address is accepted.
  assign dequeue_queue_occupancy_axis_tvalid = word_hs;
  assign dequeue_queue_occupancy_axis_tdata  = occ_tdata_q;
  assign dequeue_queue_occupancy_axis_tuser  = occ_tuser_q;
  assign dequeue_queue_occupancy_axis_tlast  = 1'b0;

  assign dequeue_word_count = cnt_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_p4_router_queue_dequeue_ctrl.sv
// Bench for p4_router_queue_dequeue_ctrl: a queue-store model answers head-pointer reads,
// expected word addresses are queued at read time and checked when the DUT issues them.
module tb_p4_router_queue_dequeue_ctrl;
  localparam int NUM_PAGES = 16, WPP = 64, BPW = 16, NE = 3, NQPP = 2, NQ = NE * NQPP, MB = 4;
  localparam int QW = 3, HW = 6, PW = 4, RW = HW + PW, AW = 10, W = AW + QW;
  localparam int ST_IDLE = 0, ST_RD = 3, ST_ISSUE = 4;

  logic clk = 1'b0, aresetn = 1'b1, enable = 1'b0;
  logic [NQ-1:0] queue_empty = '1;
  logic [NE-1:0] egress_ready = '0;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [QW-1:0] awaddr, araddr;
  logic [RW-1:0] wdata;
  logic arready = 1'b0, rvalid = 1'b0, tready = 1'b0;
  logic [RW-1:0] rdata = '0;
  logic tvalid, tlast, occ_tvalid, occ_tlast;
  logic [AW-1:0] tdata;
  logic [QW-1:0] tuser, occ_tuser;
  logic [31:0] occ_tdata, dequeue_word_count;
  logic [2:0] dbg_state;

  p4_router_queue_dequeue_ctrl #(
    .NUM_PAGES(NUM_PAGES), .WORDS_PER_PAGE(WPP), .BYTES_PER_WORD(BPW),
    .NUM_EGR_PORTS(NE), .NUM_QUEUES_PER_EGR_PORT(NQPP), .MAX_BURST_WORDS(MB)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .queue_empty(queue_empty), .egress_ready(egress_ready),
    .queue_head_pointer_a4l_awvalid(awvalid), .queue_head_pointer_a4l_awaddr(awaddr),
    .queue_head_pointer_a4l_wvalid(wvalid), .queue_head_pointer_a4l_wdata(wdata),
    .queue_head_pointer_a4l_bready(bready),
    .queue_head_pointer_a4l_arvalid(arvalid), .queue_head_pointer_a4l_araddr(araddr),
    .queue_head_pointer_a4l_arready(arready),
    .queue_head_pointer_a4l_rvalid(rvalid), .queue_head_pointer_a4l_rdata(rdata),
    .queue_head_pointer_a4l_rready(rready),
    .word_rd_addr_axis_tvalid(tvalid), .word_rd_addr_axis_tready(tready),
    .word_rd_addr_axis_tdata(tdata), .word_rd_addr_axis_tuser(tuser),
    .word_rd_addr_axis_tlast(tlast),
    .dequeue_queue_occupancy_axis_tvalid(occ_tvalid),
    .dequeue_queue_occupancy_axis_tdata(occ_tdata),
    .dequeue_queue_occupancy_axis_tuser(occ_tuser),
    .dequeue_queue_occupancy_axis_tlast(occ_tlast),
    .dequeue_word_count(dequeue_word_count), .dbg_state_o(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Queue store model and scoreboard state
  int cnt[NQ], inflight[NQ], head[NQ], page[NQ];
  logic [W-1:0] exp_q[$];
  int tuser_log[$], hs_cyc[$];
  int compared = 0, mismatched = 0;
  int words_seen = 0, occ_seen = 0, ar_seen = 0, last_araddr = -1, cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic [QW-1:0] last_user = '0;
  bit r_pending = 0;
  int r_dly = 0, aq = 0;
  logic [RW-1:0] r_data = '0;
  logic [W-1:0] r_exp = '0;
  // Stimulus controls
  bit en_ctl = 0, rand_ar = 0, rand_egr = 0;
  logic [NE-1:0] egr_ctl = '1;
  int tready_mode = 0, rdly_min = 2, rdly_max = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int q = 0; q < NQ; q++) begin
      cnt[q] = 0; inflight[q] = 0; head[q] = 0; page[q] = 0;
    end
    r_pending = 0;
    exp_q.delete(); tuser_log.delete(); hs_cyc.delete();
    words_seen = 0; occ_seen = 0; ar_seen = 0; last_araddr = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    aresetn = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (words_seen < n && c < budget) begin @(posedge clk); #2; c++; end
    compared++;
    if (words_seen < n) begin
      mismatched++;
      $display("FAIL %s: timeout with %0d words, required %0d", name, words_seen, n);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int c;
    c = 0;
    while (int'(dbg_state) != s && c < budget) begin @(posedge clk); #2; c++; end
    compared++;
    if (int'(dbg_state) != s) begin
      mismatched++;
      $display("FAIL %s: timeout in state %0d, required %0d", name, dbg_state, s);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(arvalid), 64'(0));
    check({tag, "_rready"}, 64'(rready), 64'(0));
    check({tag, "_tvalid"}, 64'(tvalid), 64'(0));
    check({tag, "_tdata"}, 64'(tdata), 64'(0));
    check({tag, "_tuser"}, 64'(tuser), 64'(0));
    check({tag, "_occ_tvalid"}, 64'(occ_tvalid), 64'(0));
    check({tag, "_occ_tdata"}, 64'(occ_tdata), 64'(0));
    check({tag, "_occ_tuser"}, 64'(occ_tuser), 64'(0));
    check({tag, "_word_count"}, 64'(dequeue_word_count), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // Driver: queue state store responder, drives inputs on the falling edge
  initial begin : driver
    forever begin
      @(negedge clk);
      enable = en_ctl;
      for (int q = 0; q < NQ; q++) queue_empty[q] = (cnt[q] <= 0);
      if (!aresetn) begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; tready = 1'b0; egress_ready = '0;
      end else begin
        egress_ready = rand_egr ? NE'($urandom_range(0, 7)) : egr_ctl;
        arready = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
        if (r_pending && r_dly > 0) r_dly--;
        rvalid = r_pending && (r_dly == 0);
        rdata = rvalid ? r_data : '0;
        case (tready_mode)
          0: tready = 1'b1;
          1: tready = 1'($urandom_range(0, 1));
          default: tready = 1'b0;
        endcase
        #1;
        if (rvalid && rready) begin
          exp_q.push_back(r_exp);
          r_pending = 0;
        end
        if (arvalid && arready) begin
          aq = int'(araddr);
          ar_seen++;
          last_araddr = aq;
          compared++;
          if (aq >= NQ || cnt[aq] - inflight[aq] <= 0) begin
            mismatched++;
            $display("FAIL ar_avail: read of queue %0d with no unconsumed word", aq);
          end else begin
            inflight[aq]++;
            r_exp  = {AW'(page[aq] * WPP + head[aq]), QW'(aq)};
            r_data = {HW'(head[aq]), PW'(page[aq])};
            head[aq]++;
            if (head[aq] == WPP) begin
              head[aq] = 0;
              page[aq] = (page[aq] + 3) % NUM_PAGES;
            end
          end
          r_pending = 1;
          r_dly = $urandom_range(rdly_min, rdly_max);
        end
        if (occ_tvalid && int'(occ_tuser) < NQ) begin
          cnt[occ_tuser]--;
          inflight[occ_tuser]--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a word address is accepted
  initial begin : monitor
    bit prev_stall;
    logic [AW-1:0] prev_data;
    logic [QW-1:0] prev_user;
    logic whs;
    logic [W-1:0] e;
    prev_stall = 0; prev_data = '0; prev_user = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!aresetn) begin prev_stall = 0; continue; end
      check("word_count", 64'(dequeue_word_count), 64'(words_seen));
      if (prev_stall) check("issue_hold", 64'({tvalid, tdata, tuser}), 64'({1'b1, prev_data, prev_user}));
      whs = tvalid && tready;
      check("occ_align", 64'(occ_tvalid), 64'(whs));
      if (whs) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL word_unexpected: addr %0d queue %0d, required no word", tdata, tuser);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'({tdata, tuser}), 64'(e));
        end
        check("occ_bytes", 64'(occ_tdata), 64'(BPW));
        check("occ_queue", 64'(occ_tuser), 64'(tuser));
        words_seen++;
        tuser_log.push_back(int'(tuser));
        hs_cyc.push_back(cyc);
        last_addr = tdata; last_user = tuser;
      end
      if (occ_tvalid) occ_seen++;
      prev_stall = tvalid && !tready;
      prev_data = tdata; prev_user = tuser;
    end
  end

  initial begin : stimulus
    int n0;
    for (int q = 0; q < NQ; q++) begin cnt[q] = 0; inflight[q] = 0; head[q] = 0; page[q] = 0; end
    #1 aresetn = 1'b0;
    #1 check_reset_outputs("rst");
    check("rst_awvalid", 64'(awvalid), 64'(0));
    check("rst_wvalid", 64'(wvalid), 64'(0));
    check("rst_bready", 64'(bready), 64'(1));
    repeat (2) @(posedge clk);
    #2 aresetn = 1'b1;
    repeat (2) @(posedge clk); #2;
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Single word from queue 3
    head[3] = 7; page[3] = 5; cnt[3] = 1; egr_ctl = '1; en_ctl = 1;
    wait_words(1, 50, "single_wait");
    repeat (6) @(posedge clk); #2;
    check("single_addr", 64'(last_addr), 64'(327));
    check("single_user", 64'(last_user), 64'(3));
    check("single_araddr", 64'(last_araddr), 64'(3));
    check("single_ar_count", 64'(ar_seen), 64'(1));
    check("single_occ_count", 64'(occ_seen), 64'(1));
    check("single_word_count", 64'(dequeue_word_count), 64'(1));
    check("single_state", 64'(dbg_state), 64'(ST_IDLE));

    // Round-robin between queues 1 and 4 in bursts of MB, with best-case latency
    do_reset();
    cnt[1] = 100; cnt[4] = 100; head[1] = 10; page[1] = 2; head[4] = 60; page[4] = 9;
    en_ctl = 1;
    wait_words(16, 400, "rr_wait");
    en_ctl = 0;
    wait_state(ST_IDLE, 50, "rr_idle");
    for (int k = 0; k < 16; k++) begin
      check("rr_seq", 64'(tuser_log[k]), 64'(((k / MB) % 2 == 0) ? 1 : 4));
      if (k > 0) check("rr_cycles", 64'(hs_cyc[k] - hs_cyc[k-1]), 64'((k % MB == 0) ? 6 : 5));
    end

    // Egress gating: port 0 blocked so queue 2 goes first
    do_reset();
    cnt[0] = 2; cnt[2] = 2; egr_ctl = 3'b110; en_ctl = 1;
    wait_words(2, 100, "gate_wait_a");
    egr_ctl = 3'b111;
    wait_words(4, 100, "gate_wait_b");
    for (int k = 0; k < 4; k++) check("gate_seq", 64'(tuser_log[k]), 64'((k < 2) ? 2 : 0));
    en_ctl = 0;

    // Backpressure held in ISSUE
    do_reset();
    cnt[5] = 1; tready_mode = 2; en_ctl = 1;
    wait_state(ST_ISSUE, 50, "bp_issue");
    repeat (5) @(posedge clk); #2;
    check("bp_no_occ", 64'(occ_seen), 64'(0));
    check("bp_tvalid", 64'(tvalid), 64'(1));
    tready_mode = 0;
    wait_words(1, 20, "bp_wait");
    repeat (4) @(posedge clk); #2;
    check("bp_occ_count", 64'(occ_seen), 64'(1));
    check("bp_word_count", 64'(words_seen), 64'(1));
    en_ctl = 0;

    // Enable dropped while the read is outstanding
    do_reset();
    cnt[1] = 10; en_ctl = 1;
    wait_state(ST_RD, 50, "en_rd");
    en_ctl = 0;
    repeat (30) @(posedge clk); #2;
    check("en_words", 64'(words_seen), 64'(1));
    check("en_ars", 64'(ar_seen), 64'(1));
    check("en_state", 64'(dbg_state), 64'(ST_IDLE));

    // Reset while the read is outstanding
    do_reset();
    cnt[2] = 5; en_ctl = 1;
    wait_state(ST_RD, 50, "mid_rst_rd");
    n0 = occ_seen;
    aresetn = 1'b0;
    #1 check_reset_outputs("mid_rst");
    check("mid_rst_occ_none", 64'(occ_seen), 64'(n0));
    model_clear();
    repeat (3) @(posedge clk);
    #2 aresetn = 1'b1;
    repeat (10) @(posedge clk); #2;
    check("mid_rst_after_occ", 64'(occ_seen), 64'(0));
    check("mid_rst_after_state", 64'(dbg_state), 64'(ST_IDLE));

    // Randomized traffic
    do_reset();
    for (int q = 0; q < NQ; q++) begin
      cnt[q] = $urandom_range(0, 5); head[q] = $urandom_range(0, WPP - 1); page[q] = $urandom_range(0, NUM_PAGES - 1);
    end
    tready_mode = 1; rand_ar = 1; rand_egr = 1; rdly_min = 1; rdly_max = 4; en_ctl = 1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 19) == 0) cnt[$urandom_range(0, NQ - 1)] += $urandom_range(1, 3);
      if ($urandom_range(0, 49) == 0) en_ctl = ~en_ctl;
    end
    en_ctl = 0; rand_egr = 0; tready_mode = 0; rand_ar = 0;
    repeat (2) @(posedge clk);
    wait_state(ST_IDLE, 200, "rand_drain");
    repeat (5) @(posedge clk); #2;
    check("rand_exp_empty", 64'(exp_q.size()), 64'(0));
    check("rand_count", 64'(dequeue_word_count), 64'(words_seen));
    check("rand_occ", 64'(occ_seen), 64'(words_seen));
    check("rand_ars", 64'(ar_seen), 64'(words_seen));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
